// File: rtl/clk_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_ctrl_pkg
// Description : Shared mode encoding and field limits for the clock block.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_e;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_W   = 4;
    localparam int MINSEC_W = 6;

endpackage
`default_nettype wire

// File: rtl/mod_n_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_n_counter
// Description : Counts 0..MAX on inc; flags the MAX->0 wrap combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_n_counter #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] value_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    assign wrap_o = inc_i && (value_q == WIDTH'(MAX));

    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (inc_i) begin
            value_d = wrap_o ? '0 : value_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule
`default_nettype wire

// File: rtl/clk_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_set_ctrl
// Description : 12-hour timekeeper with hour/minute set modes and timeout.
//               Optional blink strobe enabled by macro CLK_SET_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_set_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int HOUR_MAX      = 11,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                mode_btn,
    input  logic                inc_btn,
    output logic [HOUR_W-1:0]   hour,
    output logic [MINSEC_W-1:0] minute,
    output logic [MINSEC_W-1:0] second,
    output logic [1:0]          mode,
    output logic                blink,
    output logic                day_wrap
);

    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

    mode_e           mode_q;
    logic [TO_W-1:0] to_q;
    logic            day_wrap_q;

    logic in_run, in_set, btn_any, inc_only, timeout_hit, leave_set;
    logic sec_inc, sec_clr, sec_wrap;
    logic min_inc, min_wrap;
    logic hour_inc, hour_wrap;

    assign in_run      = (mode_q == RUN);
    assign in_set      = !in_run;
    assign btn_any     = mode_btn || inc_btn;
    assign inc_only    = inc_btn && !mode_btn;
    // A press in the same cycle as the final tick cancels the timeout.
    assign timeout_hit = in_set && tick && !btn_any &&
                         (to_q == TO_W'(TIMEOUT_TICKS - 1));
    assign leave_set   = timeout_hit || (mode_q == SET_MIN && mode_btn);

    assign sec_inc  = in_run && tick;
    assign sec_clr  = (mode_q == SET_MIN) && mode_btn;
    assign min_inc  = sec_wrap || ((mode_q == SET_MIN) && inc_only);
    // Minute wraps while setting must not carry into the hour.
    assign hour_inc = (min_wrap && in_run) || ((mode_q == SET_HR) && inc_only);

    mod_n_counter #(.WIDTH(MINSEC_W), .MAX(SEC_MAX)) u_sec (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (sec_inc),
        .clr_i   (sec_clr),
        .value_o (second),
        .wrap_o  (sec_wrap)
    );

    mod_n_counter #(.WIDTH(MINSEC_W), .MAX(MIN_MAX)) u_min (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (min_inc),
        .clr_i   (1'b0),
        .value_o (minute),
        .wrap_o  (min_wrap)
    );

    mod_n_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (hour_inc),
        .clr_i   (1'b0),
        .value_o (hour),
        .wrap_o  (hour_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= RUN;
            to_q       <= '0;
            day_wrap_q <= 1'b0;
        end else begin
            day_wrap_q <= hour_wrap && in_run;

            if (btn_any || in_run || timeout_hit) begin
                to_q <= '0;
            end else if (tick) begin
                to_q <= to_q + 1'b1;
            end

            if (mode_btn) begin
                case (mode_q)
                    RUN:     mode_q <= SET_HR;
                    SET_HR:  mode_q <= SET_MIN;
                    default: mode_q <= RUN;
                endcase
            end else if (timeout_hit) begin
                mode_q <= RUN;
            end
        end
    end

`ifdef CLK_SET_BLINK_EN
    logic blink_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q <= 1'b0;
        end else if (leave_set || in_run) begin
            blink_q <= 1'b0;
        end else if (tick) begin
            blink_q <= !blink_q;
        end
    end

    assign blink = blink_q;
`else
    logic unused_leave_set;
    assign unused_leave_set = leave_set;
    assign blink            = 1'b0;
`endif

    assign mode     = mode_q;
    assign day_wrap = day_wrap_q;

endmodule
`default_nettype wire
